// File: rtl/ca_pkg.sv
// Shared opcodes and scan-engine states for the multi-entry event calendar.
package ca_pkg;

    typedef enum logic [1:0] {
        CA_OP_COM    = 2'd0,
        CA_OP_ET     = 2'd1,
        CA_OP_CANCEL = 2'd2,
        CA_OP_NOP    = 2'd3
    } ca_op_e;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } ca_scan_e;

endpackage

// File: rtl/ca_due_cmp.sv
// Modular-time due/late test of one calendar entry against the current time.
module ca_due_cmp #(
    parameter int unsigned TIME_W      = 23,
    parameter int unsigned LATE_THRESH = 16
) (
    input  logic [TIME_W-1:0] now,
    input  logic [TIME_W-1:0] ev_time,
    output logic              due,
    output logic              late
);

    logic [TIME_W-1:0] d;

    // Event times in the past half of the wrap range, including now, are due.
    assign d    = now - ev_time;
    assign due  = ~d[TIME_W-1];
    assign late = (d >= TIME_W'(LATE_THRESH));

endmodule

// File: rtl/ca_multi.sv
// Multi-entry event calendar: staged commands, DEPTH scheduled entries, a
// round-robin scan that fires due entries on a valid/ready match port.
module ca_multi
    import ca_pkg::*;
#(
    parameter int unsigned TIME_W      = 23,
    parameter int unsigned N_THREADS   = 16,
    parameter int unsigned TID_W       = 4,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned CMD_W       = 32,
    parameter int unsigned LATE_THRESH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [1:0]                wr_op,
    input  logic [TID_W-1:0]          wr_tid,
    input  logic [CMD_W-1:0]          wr_data,
    output logic [TIME_W-1:0]         ca_time,
    output logic                      match_valid,
    input  logic                      match_ready,
    output logic [TID_W-1:0]          match_tid,
    output logic [CMD_W-1:0]          match_command,
    output logic                      match_late,
    output logic                      ca_full,
    output logic [$clog2(DEPTH):0]    ca_occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              valid;
        logic [TIME_W-1:0] ev_time;
        logic [TID_W-1:0]  tid;
        logic [CMD_W-1:0]  cmd;
    } ca_entry_t;

    ca_entry_t         entries_q [DEPTH];
    ca_entry_t         entries_d [DEPTH];
    logic [CMD_W-1:0]  stage_q   [N_THREADS];
    logic [TIME_W-1:0] time_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [OCC_W-1:0]  occ_q, occ_d;
    ca_scan_e          state_q, state_d;
    logic [TID_W-1:0]  mtid_q;
    logic [CMD_W-1:0]  mcmd_q;
    logic              mlate_q;

    logic              is_com, is_et, is_cancel;
    logic [PTR_W-1:0]  free_idx;
    logic              free_found;
    ca_entry_t         vis;
    logic              vis_due, vis_late;
    logic              out_free, cancel_hit_vis, capture, ptr_hold;

    assign ca_full   = (occ_q == OCC_W'(DEPTH));
    assign wr_ready  = !rst && ((wr_op != CA_OP_ET) || !ca_full);
    assign is_com    = wr_valid && wr_ready && (wr_op == CA_OP_COM);
    assign is_et     = wr_valid && wr_ready && (wr_op == CA_OP_ET);
    assign is_cancel = wr_valid && wr_ready && (wr_op == CA_OP_CANCEL);

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!free_found && !entries_q[i].valid) begin
                free_idx   = PTR_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign vis = entries_q[ptr_q];

    ca_due_cmp #(
        .TIME_W      (TIME_W),
        .LATE_THRESH (LATE_THRESH)
    ) u_due_cmp (
        .now     (time_q),
        .ev_time (vis.ev_time),
        .due     (vis_due),
        .late    (vis_late)
    );

    // A cancel aimed at the visited entry's thread suppresses its capture.
    assign out_free       = (state_q == ST_SCAN) || match_ready;
    assign cancel_hit_vis = is_cancel && (vis.tid == wr_tid);
    assign capture        = vis.valid && vis_due && out_free && !cancel_hit_vis;
    assign ptr_hold       = (state_q == ST_HOLD) && !match_ready;

    always_comb begin
        entries_d = entries_q;
        if (capture) begin
            entries_d[ptr_q].valid = 1'b0;
        end
        if (is_cancel) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries_q[i].tid == wr_tid) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end
        if (is_et) begin
            entries_d[free_idx].valid   = 1'b1;
            entries_d[free_idx].ev_time = wr_data[TIME_W-1:0];
            entries_d[free_idx].tid     = wr_tid;
            entries_d[free_idx].cmd     = stage_q[wr_tid];
        end
        occ_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(entries_d[i].valid);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: if (capture) state_d = ST_HOLD;
            ST_HOLD: if (match_ready && !capture) state_d = ST_SCAN;
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            for (int unsigned i = 0; i < N_THREADS; i++) begin
                stage_q[i] <= '0;
            end
            time_q  <= '0;
            ptr_q   <= '0;
            occ_q   <= '0;
            state_q <= ST_SCAN;
            mtid_q  <= '0;
            mcmd_q  <= '0;
            mlate_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            occ_q     <= occ_d;
            state_q   <= state_d;
            time_q    <= time_q + TIME_W'(1);
            if (is_com) begin
                stage_q[wr_tid] <= wr_data;
            end
            if (!ptr_hold) begin
                ptr_q <= ptr_q + PTR_W'(1);
            end
            if (capture) begin
                mtid_q  <= vis.tid;
                mcmd_q  <= vis.cmd;
                mlate_q <= vis_late;
            end
        end
    end

    assign ca_time       = time_q;
    assign match_valid   = (state_q == ST_HOLD);
    assign match_tid     = mtid_q;
    assign match_command = mcmd_q;
    assign match_late    = mlate_q;
    assign ca_occupancy  = occ_q;

endmodule
